// File: rtl/obstacle_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// obstacle_spawn_scheduler
//
// Central controller for a pool of NUM_OBSTACLES obstacle instances.
//   - Paces spawn events on frame boundaries (one event every SPAWN_PERIOD
//     startOfFrame pulses while gameplay runs).
//   - Hands each spawn the lowest-index free slot and a pseudo-random start X
//     drawn from a 10-bit Fibonacci LFSR (x^10 + x^7 + 1).
//   - Tracks which slots are alive; alive[i] is the enable of instance i.
//   - Arbitrates simultaneous hits with fixed priority (lowest index first),
//     killing at most one obstacle per clock and counting kills (saturating).
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   game_run     in   level; 1 = gameplay active
//   startOfFrame in   one-clock pulse per frame
//   hit_req      in   per-slot "shot hit this obstacle" level
//   alive        out  per-slot obstacle enable
//   spawn_valid  out  one-clock pulse: a slot was spawned
//   spawn_slot   out  spawned slot index (valid with spawn_valid)
//   spawn_x      out  signed start X (valid with spawn_valid)
//   kill_valid   out  one-clock pulse: a slot was killed
//   kill_slot    out  killed slot index (valid with kill_valid)
//   kill_count   out  kills since run start, saturating at 255
// -----------------------------------------------------------------------------
module obstacle_spawn_scheduler #(
  parameter int         NUM_OBSTACLES = 4,
  parameter int         SLOT_W        = 2,
  parameter int         SPAWN_PERIOD  = 60,
  parameter int         X_MIN         = 30,
  parameter int         X_RANGE       = 480,
  parameter logic [9:0] LFSR_SEED     = 10'h2A5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     game_run,
  input  logic                     startOfFrame,
  input  logic [NUM_OBSTACLES-1:0] hit_req,
  output logic [NUM_OBSTACLES-1:0] alive,
  output logic                     spawn_valid,
  output logic [SLOT_W-1:0]        spawn_slot,
  output logic signed [10:0]       spawn_x,
  output logic                     kill_valid,
  output logic [SLOT_W-1:0]        kill_slot,
  output logic [7:0]               kill_count
);

  localparam int              FC_W    = (SPAWN_PERIOD > 2) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(SPAWN_PERIOD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                   r_state;
  logic [FC_W-1:0]          r_frame_cnt;
  logic                     r_pending;
  logic [9:0]               r_lfsr;
  logic [NUM_OBSTACLES-1:0] r_alive;
  logic                     r_spawn_valid;
  logic [SLOT_W-1:0]        r_spawn_slot;
  logic signed [10:0]       r_spawn_x;
  logic                     r_kill_valid;
  logic [SLOT_W-1:0]        r_kill_slot;
  logic [7:0]               r_kill_count;

  logic [9:0]               w_lfsr_next;
  logic                     w_spawn_event;
  logic                     w_req;
  logic [NUM_OBSTACLES-1:0] w_elig;
  logic                     w_free_any;
  logic [SLOT_W-1:0]        w_free_idx;
  logic [NUM_OBSTACLES-1:0] w_spawn_mask;
  logic                     w_kill_any;
  logic [SLOT_W-1:0]        w_kill_idx;
  logic [NUM_OBSTACLES-1:0] w_kill_mask;

  // Fold a 9-bit offset (0..511) into X_MIN..X_MIN+X_RANGE: offsets past the
  // range wrap back to the start instead of being clipped, which keeps the
  // distribution roughly flat.
  function automatic logic signed [10:0] fold_x(input logic [8:0] off);
    logic [10:0] v;
    v = 11'(X_MIN) + {2'b00, off};
    if ({2'b00, off} > 11'(X_RANGE)) begin
      v = v - 11'(X_RANGE + 1);
    end
    return $signed(v);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_lfsr_next = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};

  // Spawn and kill both look at the registered alive vector. A live kill
  // winner can therefore never be the free slot picked for a spawn, and the
  // two masks are always disjoint.
  always_comb begin
    w_spawn_event = (r_state == RUN) && game_run && startOfFrame &&
                    (r_frame_cnt == FC_LAST);
    w_req         = w_spawn_event || r_pending;
    w_elig        = hit_req & r_alive;
    w_free_any    = 1'b0;
    w_free_idx    = '0;
    w_spawn_mask  = '0;
    w_kill_any    = 1'b0;
    w_kill_idx    = '0;
    w_kill_mask   = '0;
    // Scan high to low so the last hit found is the lowest index.
    for (int i = NUM_OBSTACLES - 1; i >= 0; i--) begin
      if (!r_alive[i]) begin
        w_free_any   = 1'b1;
        w_free_idx   = SLOT_W'(i);
        w_spawn_mask = '0;
        w_spawn_mask[i] = 1'b1;
      end
      if (w_elig[i]) begin
        w_kill_any  = 1'b1;
        w_kill_idx  = SLOT_W'(i);
        w_kill_mask = '0;
        w_kill_mask[i] = 1'b1;
      end
    end
    if (!(w_req && w_free_any)) begin
      w_spawn_mask = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_frame_cnt   <= '0;
      r_pending     <= 1'b0;
      r_lfsr        <= LFSR_SEED;
      r_alive       <= '0;
      r_spawn_valid <= 1'b0;
      r_spawn_slot  <= '0;
      r_spawn_x     <= '0;
      r_kill_valid  <= 1'b0;
      r_kill_slot   <= '0;
      r_kill_count  <= '0;
    end else begin
      r_lfsr        <= w_lfsr_next;
      r_spawn_valid <= 1'b0;
      r_kill_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_alive      <= '0;
          r_frame_cnt  <= '0;
          r_pending    <= 1'b0;
          r_kill_count <= '0;
          if (game_run) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!game_run) begin
            // Leaving the run drops any in-flight spawn or kill this cycle.
            r_state      <= IDLE;
            r_alive      <= '0;
            r_frame_cnt  <= '0;
            r_pending    <= 1'b0;
            r_kill_count <= '0;
          end else begin
            if (startOfFrame) begin
              r_frame_cnt <= (r_frame_cnt == FC_LAST) ? '0 : r_frame_cnt + FC_W'(1);
            end
            if (w_req) begin
              if (w_free_any) begin
                r_spawn_valid <= 1'b1;
                r_spawn_slot  <= w_free_idx;
                r_spawn_x     <= fold_x(r_lfsr[8:0]);
                r_pending     <= 1'b0;
              end else begin
                // Only one request is remembered; later events are dropped.
                r_pending <= 1'b1;
              end
            end
            if (w_kill_any) begin
              r_kill_valid <= 1'b1;
              r_kill_slot  <= w_kill_idx;
              r_kill_count <= sat_inc8(r_kill_count);
            end
            r_alive <= (r_alive | w_spawn_mask) & ~w_kill_mask;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign alive       = r_alive;
  assign spawn_valid = r_spawn_valid;
  assign spawn_slot  = r_spawn_slot;
  assign spawn_x     = r_spawn_x;
  assign kill_valid  = r_kill_valid;
  assign kill_slot   = r_kill_slot;
  assign kill_count  = r_kill_count;

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_obstacle_spawn_scheduler
//
// Directed scenarios with literal expectations followed by a randomized run.
// A behavioural model (slot array, frame counter, pending flag, LFSR integer)
// predicts every output; a negedge process compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_obstacle_spawn_scheduler;

  localparam int         N    = 4;
  localparam int         SW   = 2;
  localparam int         SP   = 4;
  localparam int         XMIN = 30;
  localparam int         XR   = 480;
  localparam logic [9:0] SEED = 10'h2A5;

  logic               clk = 1'b0;
  logic               reset;
  logic               game_run;
  logic               sof;
  logic [N-1:0]       hit_req;
  logic [N-1:0]       alive;
  logic               spawn_valid;
  logic [SW-1:0]      spawn_slot;
  logic signed [10:0] spawn_x;
  logic               kill_valid;
  logic [SW-1:0]      kill_slot;
  logic [7:0]         kill_count;

  obstacle_spawn_scheduler #(
    .NUM_OBSTACLES(N),
    .SLOT_W       (SW),
    .SPAWN_PERIOD (SP),
    .X_MIN        (XMIN),
    .X_RANGE      (XR),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .game_run    (game_run),
    .startOfFrame(sof),
    .hit_req     (hit_req),
    .alive       (alive),
    .spawn_valid (spawn_valid),
    .spawn_slot  (spawn_slot),
    .spawn_x     (spawn_x),
    .kill_valid  (kill_valid),
    .kill_slot   (kill_slot),
    .kill_count  (kill_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_run;
  int m_frames;
  bit m_pend;
  bit m_alive[N];
  int m_count;
  int m_lfsr;
  bit e_sv;
  bit e_kv;
  int e_sslot;
  int e_kslot;
  int e_x;

  function automatic int alive_vec();
    int v;
    v = 0;
    for (int i = 0; i < N; i++) if (m_alive[i]) v = v | (1 << i);
    return v;
  endfunction

  task automatic model_clear();
    m_frames = 0;
    m_pend   = 0;
    m_count  = 0;
    for (int i = 0; i < N; i++) m_alive[i] = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_run   = 0;
    m_lfsr  = int'(SEED);
    e_sv    = 0;
    e_kv    = 0;
    e_sslot = 0;
    e_kslot = 0;
    e_x     = 0;
  endtask

  task automatic model_step();
    bit old[N];
    bit ev;
    int fr;
    int ki;
    int off;
    e_sv = 0;
    e_kv = 0;
    if (!m_run) begin
      model_clear();
      m_run = game_run;
    end else if (!game_run) begin
      model_clear();
      m_run = 0;
    end else begin
      old = m_alive;
      ev  = 0;
      if (sof) begin
        m_frames++;
        if (m_frames == SP) begin
          ev       = 1;
          m_frames = 0;
        end
      end
      if (ev || m_pend) begin
        fr = -1;
        for (int i = 0; i < N; i++) if (!old[i]) begin fr = i; break; end
        if (fr >= 0) begin
          m_alive[fr] = 1;
          e_sv    = 1;
          e_sslot = fr;
          off     = m_lfsr & 511;
          e_x     = (off <= XR) ? XMIN + off : XMIN + off - XR - 1;
          m_pend  = 0;
        end else begin
          m_pend = 1;
        end
      end
      ki = -1;
      for (int i = 0; i < N; i++) if (hit_req[i] && old[i]) begin ki = i; break; end
      if (ki >= 0) begin
        m_alive[ki] = 0;
        e_kv    = 1;
        e_kslot = ki;
        if (m_count < 255) m_count++;
      end
    end
    m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1)) & 1023;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("alive", int'(alive), alive_vec());
    chk("spawn_valid", int'(spawn_valid), int'(e_sv));
    chk("kill_valid", int'(kill_valid), int'(e_kv));
    chk("kill_count", int'(kill_count), m_count);
    if (e_sv) begin
      chk("spawn_slot", int'(spawn_slot), e_sslot);
      chk("spawn_x", int'(spawn_x), e_x);
    end
    if (e_kv) chk("kill_slot", int'(kill_slot), e_kslot);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic frame();
    sof = 1'b1;
    step();
    sof = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    game_run = 1'b0;
    sof      = 1'b0;
    hit_req  = '0;
    repeat (2) step();
    chk("rst_alive", int'(alive), 0);
    chk("rst_spawn_valid", int'(spawn_valid), 0);
    chk("rst_kill_valid", int'(kill_valid), 0);
    chk("rst_kill_count", int'(kill_count), 0);
    chk("rst_spawn_x", int'(spawn_x), 0);
    chk("rst_spawn_slot", int'(spawn_slot), 0);
    chk("rst_kill_slot", int'(kill_slot), 0);
    reset = 1'b0;
    step();

    // Basic spawn: first event on the SP-th frame after entering RUN.
    game_run = 1'b1;
    step();
    repeat (SP - 1) frame();
    chk("pre_spawn_none", int'(spawn_valid), 0);
    frame();
    chk("basic_spawn_valid", int'(spawn_valid), 1);
    chk("basic_spawn_slot", int'(spawn_slot), 0);
    chk("basic_alive", int'(alive), 1);
    chk("basic_x_range", int'(spawn_x >= 11'sd30 && spawn_x <= 11'sd510), 1);

    // Fill the pool in slot order.
    for (int k = 1; k < N; k++) begin
      repeat (SP - 1) frame();
      frame();
      chk("fill_spawn_valid", int'(spawn_valid), 1);
      chk("fill_spawn_slot", int'(spawn_slot), k);
    end
    chk("full_alive", int'(alive), 4'b1111);

    // Event with a full pool becomes pending.
    repeat (SP) frame();
    chk("full_no_spawn", int'(spawn_valid), 0);
    hit_req = 4'b0100;
    step();
    chk("pend_kill_valid", int'(kill_valid), 1);
    chk("pend_kill_slot", int'(kill_slot), 2);
    chk("pend_kill_alive", int'(alive), 4'b1011);
    chk("pend_no_spawn_yet", int'(spawn_valid), 0);
    hit_req = 4'b0000;
    step();
    chk("pend_spawn_valid", int'(spawn_valid), 1);
    chk("pend_spawn_slot", int'(spawn_slot), 2);
    chk("pend_alive", int'(alive), 4'b1111);

    // Fixed-priority arbitration, then a hit on a dead slot.
    hit_req = 4'b1010;
    step();
    chk("arb1_slot", int'(kill_slot), 1);
    chk("arb1_alive", int'(alive), 4'b1101);
    step();
    chk("arb2_valid", int'(kill_valid), 1);
    chk("arb2_slot", int'(kill_slot), 3);
    chk("arb2_alive", int'(alive), 4'b0101);
    hit_req = 4'b0100;
    step();
    chk("arb3_slot", int'(kill_slot), 2);
    step();
    chk("dead_hit_no_kill", int'(kill_valid), 0);
    chk("dead_hit_alive", int'(alive), 4'b0001);
    chk("count_after_arb", int'(kill_count), 4);
    hit_req = 4'b0000;

    // Spawn and kill in the same cycle.
    repeat (SP - 1) frame();
    hit_req = 4'b0001;
    frame();
    hit_req = 4'b0000;
    chk("coll_kill_valid", int'(kill_valid), 1);
    chk("coll_kill_slot", int'(kill_slot), 0);
    chk("coll_spawn_valid", int'(spawn_valid), 1);
    chk("coll_spawn_slot", int'(spawn_slot), 1);
    chk("coll_alive", int'(alive), 4'b0010);

    repeat (2 * SP) frame();
    chk("stop_pre_alive", int'(alive), 4'b0111);

    // Stop: game_run=0 wins over frame and hit.
    game_run = 1'b0;
    sof      = 1'b1;
    hit_req  = 4'b0001;
    step();
    chk("stop_alive", int'(alive), 0);
    chk("stop_count", int'(kill_count), 0);
    chk("stop_no_kill", int'(kill_valid), 0);
    repeat (SP + 1) step();
    chk("idle_alive", int'(alive), 0);
    chk("idle_no_spawn", int'(spawn_valid), 0);
    sof     = 1'b0;
    hit_req = 4'b0000;

    // Async reset while a spawn pulse is showing.
    game_run = 1'b1;
    step();
    repeat (SP - 1) frame();
    frame();
    chk("ar_pre_pulse", int'(spawn_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_spawn_valid", int'(spawn_valid), 0);
    chk("ar_alive", int'(alive), 0);
    chk("ar_spawn_x", int'(spawn_x), 0);
    chk("ar_spawn_slot", int'(spawn_slot), 0);
    step();
    reset = 1'b0;
    step();

    // Saturation: spawn every SP cycles, kill each one immediately.
    sof     = 1'b1;
    hit_req = 4'b1111;
    repeat (1300) step();
    chk("sat_count", int'(kill_count), 255);
    sof     = 1'b0;
    hit_req = 4'b0000;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      game_run = ($urandom_range(0, 199) != 0);
      sof      = ($urandom_range(0, 2) == 0);
      hit_req  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
